// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter command sequencer.
// Op codes, FSM states and the counter width.
package counter_ctrl_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_RUN   = 2'd1,
      OP_UNTIL = 2'd2,
      OP_DRIVE = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_UNTIL = 2'd3
   } state_e;

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the 8-bit programmable counter.
// Turns LOAD / RUN / RUN_UNTIL / SET_DRIVE into cycle-exact controls.
module counter_cmd_sequencer
   import counter_ctrl_pkg::*;
#(
   parameter logic DRIVE_RST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   input  logic             cmd_abort,
   input  logic [CNT_W-1:0] ctr_count,
   output logic             ctr_load,
   output logic [CNT_W-1:0] ctr_load_val,
   output logic             ctr_count_en,
   output logic             ctr_drive_en,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] arg_q, arg_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             drive_q, drive_d;
   logic             done_q, done_d;
   logic             accept;
   logic             at_target;

   assign cmd_ready    = (state_q == S_IDLE) & ena;
   assign accept       = cmd_valid & cmd_ready;
   assign at_target    = (ctr_count == arg_q);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q & ena;
   assign ctr_drive_en = drive_q;
   assign ctr_load     = ena & (state_q == S_LOAD);
   assign ctr_load_val = (state_q == S_LOAD) ? arg_q : '0;
   assign ctr_count_en = ena & ((state_q == S_RUN) |
                         ((state_q == S_UNTIL) & ~at_target));

   // State, operand, remaining count, drive level and done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         arg_q   <= '0;
         rem_q   <= '0;
         drive_q <= DRIVE_RST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         arg_q   <= arg_d;
         rem_q   <= rem_d;
         drive_q <= drive_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; everything holds while ena is low.
   always_comb begin
      state_d = state_q;
      arg_d   = arg_q;
      rem_d   = rem_q;
      drive_d = drive_q;
      done_d  = 1'b0;
      if (ena) begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  arg_d = cmd_arg;
                  unique case (op_e'(cmd_op))
                     OP_LOAD:  state_d = S_LOAD;
                     OP_RUN: begin
                        state_d = S_RUN;
                        rem_d   = cmd_arg - 8'd1;
                     end
                     OP_UNTIL: state_d = S_UNTIL;
                     OP_DRIVE: begin
                        drive_d = cmd_arg[0];
                        done_d  = 1'b1;
                     end
                  endcase
               end
            end
            S_LOAD: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            S_RUN: begin
               if (rem_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  rem_d = rem_q - 8'd1;
               end
            end
            S_UNTIL: begin
               if (at_target) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         endcase
         // Abort overrides any completion in the same cycle.
         if (cmd_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
         end
      end
   end

endmodule
